// File: rtl/mrd_pkg.sv
// Shared defaults, FSM encoding and 4-PAM Gray codes for the final demapper.
package mrd_pkg;

  localparam int DIMENSION_DEF = 16;
  localparam int WIDTH_DEF     = 8;
  localparam int FRAC_BITS_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [1:0] GRAY_P3 = 2'b10;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_M3 = 2'b00;

endpackage

// File: rtl/pam4_slicer.sv
// Combinational 4-PAM hard-decision slicer with thresholds at 0 and +/-2.0.
module pam4_slicer
  import mrd_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [WIDTH-1:0] soft_i,
  output logic        [1:0]       code_o
);

  localparam int THR_I = 2 * (2 ** FRAC_BITS);
  // Two guard bits keep +/-T representable regardless of WIDTH.
  localparam logic signed [WIDTH+1:0] THR     = (WIDTH+2)'(THR_I);
  localparam logic signed [WIDTH+1:0] NEG_THR = -THR;

  logic signed [WIDTH+1:0] x_s;

  assign x_s = {{2{soft_i[WIDTH-1]}}, soft_i};

  // Decision regions; zero belongs to +1 and -T belongs to -1.
  always_comb begin
    code_o = GRAY_M3;
    if (x_s >= THR) begin
      code_o = GRAY_P3;
    end else if (!x_s[WIDTH+1]) begin
      code_o = GRAY_P1;
    end else if (x_s >= NEG_THR) begin
      code_o = GRAY_M1;
    end else begin
      code_o = GRAY_M3;
    end
  end

endmodule

// File: rtl/x_final_demapper.sv
// Captures a detector estimate frame and streams it one sliced symbol per
// accepted handshake, with back-to-back frame chaining and overrun flagging.
module x_final_demapper
  import mrd_pkg::*;
#(
  parameter int DIMENSION = DIMENSION_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  localparam int IW       = (DIMENSION > 1) ? $clog2(DIMENSION) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIMENSION*WIDTH-1:0] x_in,
  input  logic                       x_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_sym,
  output logic [WIDTH-1:0]           out_soft,
  output logic [IW-1:0]              out_idx,
  output logic                       out_last,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DIMENSION - 1);
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [DIMENSION*WIDTH-1:0] shadow_q, shadow_d;
  logic                       frame_done_q, frame_done_d;
  logic                       overrun_q, overrun_d;

  logic [WIDTH-1:0] elem_s [DIMENSION];
  logic [WIDTH-1:0] sel_s;
  logic             fire_s;
  logic             last_s;

  for (genvar g = 0; g < DIMENSION; g++) begin : g_elem
    assign elem_s[g] = shadow_q[g*WIDTH +: WIDTH];
  end

  assign sel_s  = elem_s[idx_q];
  assign last_s = (idx_q == LAST_IDX);
  assign fire_s = (state_q == ST_SEND) && out_ready;

  assign out_valid  = (state_q == ST_SEND);
  assign busy       = (state_q == ST_SEND);
  assign out_soft   = sel_s;
  assign out_idx    = idx_q;
  assign out_last   = last_s;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  pam4_slicer #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_slicer (
    .soft_i (sel_s),
    .code_o (out_sym)
  );

  // Next-state: frame capture, index advance and chaining on the last transfer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (x_valid) begin
          shadow_d = x_in;
          idx_d    = {IW{1'b0}};
          state_d  = ST_SEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (fire_s && last_s) begin
          frame_done_d = 1'b1;
          idx_d        = {IW{1'b0}};
          // A new frame arriving exactly on the last transfer is chained, not dropped.
          if (x_valid) begin
            shadow_d = x_in;
            state_d  = ST_SEND;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          if (fire_s) begin
            idx_d = idx_q + IDX_ONE;
          end else begin
            idx_d = idx_q;
          end
          if (x_valid) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // State, index, shadow frame and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IW{1'b0}};
      shadow_q     <= {(DIMENSION*WIDTH){1'b0}};
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_x_final_demapper.sv
// Directed self-checking bench for x_final_demapper at default parameters.
module tb_x_final_demapper;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] x_in;
  logic         x_valid;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_sym;
  logic [7:0]   out_soft;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [7:0] fa [16];
  logic signed [7:0] fb [16];
  logic signed [7:0] fc [16];
  int         bv [8] = '{0, 32, -32, -33, 31, -1, 127, -128};
  logic [1:0] bc [8] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00};

  x_final_demapper dut (
    .clk        (clk),
    .rst        (rst),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sym    (out_sym),
    .out_soft   (out_soft),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack(input logic signed [7:0] f [16]);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = f[i];
    return v;
  endfunction

  function automatic logic [1:0] exp_code(input int x);
    if (x >= 32)       return 2'b10;
    else if (x >= 0)   return 2'b11;
    else if (x >= -32) return 2'b01;
    else               return 2'b00;
  endfunction

  task automatic test_reset;
    rst = 1'b1; x_valid = 1'b0; out_ready = 1'b0; x_in = '0;
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if (out_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    n_checks++; if (out_soft !== 8'd0) begin n_fail++; $display("FAIL reset_soft got %0d want 0", out_soft); end
    n_checks++; if (out_sym !== 2'b11) begin n_fail++; $display("FAIL reset_sym got %b want 11", out_sym); end
    rst = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < 16; i++) fa[i] = 8'(i * 8 - 64);
    x_in = pack(fa); x_valid = 1'b1; out_ready = 1'b1;
    tick;
    x_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_idx !== 4'(i)) begin n_fail++; $display("FAIL full_idx[%0d] got %0d want %0d", i, out_idx, i); end
      n_checks++; if (out_soft !== fa[i]) begin n_fail++; $display("FAIL full_soft[%0d] got %0d want %0d", i, $signed(out_soft), fa[i]); end
      n_checks++; if (out_sym !== exp_code(i * 8 - 64)) begin n_fail++; $display("FAIL full_sym[%0d] got %b want %b", i, out_sym, exp_code(i * 8 - 64)); end
      n_checks++; if (out_last !== (i == 15)) begin n_fail++; $display("FAIL full_last[%0d] got %b", i, out_last); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL full_done_early[%0d] got %b want 0", i, frame_done); end
      tick;
    end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", frame_done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_busy got %b want 0", busy); end
    tick;
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse got %b want 0", frame_done); end
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < 16; i++) fb[i] = (i < 8) ? 8'(bv[i]) : 8'(i);
    x_in = pack(fb); x_valid = 1'b1; out_ready = 1'b1;
    tick;
    x_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        n_checks++; if (out_sym !== bc[i]) begin n_fail++; $display("FAIL bound_sym[%0d] x=%0d got %b want %b", i, bv[i], out_sym, bc[i]); end
      end
      tick;
    end
    tick;
  endtask

  task automatic test_backpressure;
    logic [3:0] rp;
    int k;
    rp = 4'b1001;
    k = 0;
    for (int i = 0; i < 16; i++) fc[i] = 8'(i * 13 - 100);
    x_in = pack(fc); x_valid = 1'b1; out_ready = 1'b0;
    tick;
    x_valid = 1'b0;
    for (int c = 0; c < 100 && k < 16; c++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[c%0d] got %b want 1", c, out_valid); end
      n_checks++; if (out_idx !== 4'(k)) begin n_fail++; $display("FAIL bp_idx[c%0d] got %0d want %0d", c, out_idx, k); end
      n_checks++; if (out_soft !== fc[k]) begin n_fail++; $display("FAIL bp_soft[c%0d] got %0d want %0d", c, $signed(out_soft), fc[k]); end
      n_checks++; if (out_sym !== exp_code(k * 13 - 100)) begin n_fail++; $display("FAIL bp_sym[c%0d] got %b want %b", c, out_sym, exp_code(k * 13 - 100)); end
      n_checks++; if (out_last !== (k == 15)) begin n_fail++; $display("FAIL bp_last[c%0d] got %b", c, out_last); end
      out_ready = rp[c % 4];
      tick;
      if (out_ready) k++;
    end
    n_checks++; if (k !== 16) begin n_fail++; $display("FAIL bp_count got %0d want 16", k); end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", frame_done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", out_valid); end
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_back_to_back;
    x_in = pack(fa); x_valid = 1'b1; out_ready = 1'b1;
    tick;
    x_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_idx !== 4'(i)) begin n_fail++; $display("FAIL b2b_a_idx[%0d] got %0d", i, out_idx); end
      if (i == 15) begin
        x_in = pack(fb); x_valid = 1'b1;
      end
      tick;
      x_valid = 1'b0;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got %b want 1", out_valid); end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", frame_done); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_idx !== 4'(i)) begin n_fail++; $display("FAIL b2b_b_idx[%0d] got %0d", i, out_idx); end
      n_checks++; if (out_soft !== fb[i]) begin n_fail++; $display("FAIL b2b_b_soft[%0d] got %0d want %0d", i, $signed(out_soft), fb[i]); end
      tick;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", out_valid); end
    tick;
  endtask

  task automatic test_overrun_reset;
    x_in = pack(fc); x_valid = 1'b1; out_ready = 1'b1;
    tick;
    x_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_soft !== fc[i]) begin n_fail++; $display("FAIL ovr_soft[%0d] got %0d want %0d", i, $signed(out_soft), fc[i]); end
      n_checks++; if (overrun !== (i > 5)) begin n_fail++; $display("FAIL ovr_flag[%0d] got %b", i, overrun); end
      if (i == 5) begin
        x_in = pack(fa); x_valid = 1'b1;
      end
      tick;
      x_valid = 1'b0;
    end
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL ovr_done got %b want 1", frame_done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_idle got %b want 0", out_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    x_in = pack(fb); x_valid = 1'b1;
    tick;
    x_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    n_checks++; if (out_idx !== 4'd9) begin n_fail++; $display("FAIL rst_pre_idx got %0d want 9", out_idx); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
    n_checks++; if (out_idx !== 4'd0) begin n_fail++; $display("FAIL rst_mid_idx got %0d want 0", out_idx); end
    n_checks++; if (out_soft !== 8'd0) begin n_fail++; $display("FAIL rst_mid_soft got %0d want 0", out_soft); end
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_overrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/x_final_demapper.md
X_FINAL_DEMAPPER -- requirements
Module: x_final_demapper

Interface
REQ-001 Parameter DIMENSION, default 16, number of detected symbols per frame.
REQ-002 Parameter WIDTH, default 8, bits per signed symbol estimate.
REQ-003 Parameter FRAC_BITS, default 4, fractional bits of the estimate (1.0 = 2^FRAC_BITS).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 x_in  input  DIMENSION*WIDTH  signed detector estimate vector; element i at bits [i*WIDTH +: WIDTH].
REQ-007 x_valid  input  1  one-cycle pulse: x_in holds a complete frame.
REQ-008 out_valid  output  1  a symbol is presented.
REQ-009 out_ready  input  1  downstream accepts the symbol when high with out_valid.
REQ-010 out_sym  output  2  Gray-coded 4-PAM hard decision.
REQ-011 out_soft  output  WIDTH  raw signed estimate of the presented element.
REQ-012 out_idx  output  clog2(DIMENSION)  index of the presented element.
REQ-013 out_last  output  1  high when out_idx = DIMENSION-1.
REQ-014 busy  output  1  frame held and not fully transferred.
REQ-015 frame_done  output  1  one-cycle pulse after the last transfer of a frame.
REQ-016 overrun  output  1  sticky: a frame was dropped.

Function
REQ-017 FSM states IDLE and SEND; IDLE -> SEND on x_valid; SEND -> IDLE on the last transfer unless x_valid occurs in the same cycle.
REQ-018 In IDLE, x_valid captures x_in into a shadow register and sets idx to 0; out_valid is high from the following cycle (latency 1).
REQ-019 In SEND, out_valid = 1; each cycle with out_valid && out_ready advances idx by 1.
REQ-020 out_valid && !out_ready holds idx, out_sym, out_soft, out_idx and out_last stable.
REQ-021 Transfer of idx = DIMENSION-1 ends the frame; frame_done pulses the next cycle; idx wraps to 0.
REQ-022 x_valid in the same cycle as the last transfer loads the new frame, stays in SEND, gives no gap, does not set overrun, and still pulses frame_done.
REQ-023 x_valid in SEND other than on the last-transfer cycle is ignored, the shadow register is unchanged, and overrun is set until reset.
REQ-024 The slicer is combinational on the shadow element selected by idx, with threshold T = 2*2^FRAC_BITS (32 at defaults).
REQ-025 Slicer decisions: x >= T -> +3, code 10; 0 <= x < T -> +1, code 11; -T <= x < 0 -> -1, code 01; x < -T -> -3, code 00.
REQ-026 Slicer boundaries: x = 0 -> 11; x = T -> 10; x = -T -> 01; most-negative value -> 00.
REQ-027 busy = (state == SEND); a full frame takes DIMENSION cycles with out_ready held high.

Reset
REQ-028 Assertion of rst at any time, including mid-frame, forces IDLE, idx = 0, shadow register = 0, and out_valid, busy, frame_done and overrun = 0.
REQ-029 Reset abandons a partial frame; no symbol is presented until the next x_valid after reset release.

Structure
REQ-030 Shared package mrd_pkg holds DIMENSION, WIDTH, FRAC_BITS defaults, the FSM state encoding and the four Gray-code constants.
REQ-031 The slicer is one combinational sub-module, pam4_slicer (WIDTH, FRAC_BITS in; soft in; 2-bit code out).

Verification
REQ-032 Frame of elements i*8-64 (i = 0..15), out_ready = 1 -> 16 consecutive transfers starting 1 cycle after x_valid; codes match REQ-025; frame_done pulses 1 cycle after idx 15.
REQ-033 Elements {0, 32, -32, -33, 31, -1, 127, -128} -> codes {11, 10, 01, 00, 11, 01, 10, 00}.
REQ-034 out_ready toggling 1,0,0,1 while a frame is sent -> outputs held during the 0 cycles; all 16 elements delivered exactly once, in order.
REQ-035 Second x_valid on the idx = 15 transfer cycle -> next cycle shows the new frame's element 0; overrun = 0; frame_done = 1.
REQ-036 x_valid at idx = 5 -> old frame completes unchanged and overrun = 1; rst asserted at idx = 9 -> out_valid = 0 and state IDLE immediately, overrun cleared.
